// File: rtl/uart_receiver_fifo.sv
// 8N1 UART receiver with a 2-flop input synchronizer and a show-ahead byte FIFO.
// The CPU pops one byte per rd_en pulse; frame_err and overrun are sticky until clr_err.
module uart_receiver_fifo #(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD_RATE   = 1_000_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rxd,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic               rx_meta, rx_s;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;

    logic               mid_stop, push, frame_set, pop, full, push_ok, ovr_set;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    cnt   <= HALF_BIT;
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rx_s) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        cnt     <= FULL_BIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg   <= {rx_s, shreg[7:1]};
                        cnt     <= FULL_BIT;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else state <= rx_s ? IDLE : BREAK;
                end
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Push and frame-error events fire on the mid-stop-bit edge itself so the FIFO updates on that edge.
    assign mid_stop  = (state == STOP) && (cnt == '0);
    assign push      = mid_stop && rx_s;
    assign frame_set = mid_stop && !rx_s;
    assign full      = (count == DEPTH_C);
    assign pop       = rd_en && (count != '0);
    assign push_ok   = push && (!full || pop);
    assign ovr_set   = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
            if (frame_set)    frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (ovr_set)      overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
        end
    end

    assign rx_valid = (count != '0);
    assign rx_count = count;
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_receiver_fifo.sv
// Bench for uart_receiver_fifo at 12 clk/bit, FIFO depth 4, against a queue-based model.
module tb_uart_receiver_fifo;

    logic       clk = 1'b0;
    logic       resetn, rxd, rd_en, clr_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       frame_err, overrun;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] q[$];
    logic       m_fe = 1'b0;
    logic       m_ov = 1'b0;

    uart_receiver_fifo #(.CLK_FREQ_HZ(12_000_000), .BAUD_RATE(1_000_000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .rxd(rxd), .rd_en(rd_en), .clr_err(clr_err),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] m_head();
        return (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    // Model: a completed good frame is stored if there is room, otherwise lost with overrun.
    task automatic model_push(input logic [7:0] b);
        if (q.size() < 4) q.push_back(b);
        else m_ov = 1'b1;
    endtask

    // Called at a negedge; leaves rxd at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (12) @(negedge clk);
        end
        rxd = stop;
        repeat (12) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
        model_push(b);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_pop(input string tag);
        n_total++; if (rx_data !== m_head()) $display("FAIL %s pre-pop head got %h exp %h", tag, rx_data, m_head()); else n_pass++;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        n_total++; if (rx_count !== 3'(q.size())) $display("FAIL %s post-pop count got %0d exp %0d", tag, rx_count, q.size()); else n_pass++;
        n_total++; if (rx_data !== m_head()) $display("FAIL %s post-pop head got %h exp %h", tag, rx_data, m_head()); else n_pass++;
    endtask

    task automatic test_reset();
        resetn = 1'b0; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if ({rx_data, rx_valid, rx_count, frame_err, overrun} !== 13'd0) $display("FAIL reset outputs got %h exp 0", {rx_data, rx_valid, rx_count, frame_err, overrun}); else n_pass++;
        resetn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_byte();
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (116) @(posedge clk);
                #1;
                n_total++; if (rx_valid !== 1'b0) $display("FAIL latency early rx_valid got %b exp 0", rx_valid); else n_pass++;
                @(posedge clk);
                #1;
                n_total++; if (rx_valid !== 1'b1) $display("FAIL latency edge117 rx_valid got %b exp 1", rx_valid); else n_pass++;
            end
        join
        model_push(8'h55);
        n_total++; if (rx_data !== 8'h55) $display("FAIL single data got %h exp 55", rx_data); else n_pass++;
        n_total++; if (rx_count !== 3'd1) $display("FAIL single count got %0d exp 1", rx_count); else n_pass++;
        do_pop("single");
        n_total++; if (rx_valid !== 1'b0) $display("FAIL single empty rx_valid got %b exp 0", rx_valid); else n_pass++;
        do_pop("empty_pop");
        n_total++; if ({frame_err, overrun} !== 2'b00) $display("FAIL empty_pop flags got %b exp 00", {frame_err, overrun}); else n_pass++;
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 5; i++) send_byte(8'h41 + 8'(i));
        n_total++; if (rx_count !== 3'd4) $display("FAIL ovr count got %0d exp 4", rx_count); else n_pass++;
        n_total++; if (rx_data !== 8'h41) $display("FAIL ovr head got %h exp 41", rx_data); else n_pass++;
        n_total++; if (overrun !== m_ov || m_ov !== 1'b1) $display("FAIL ovr flag got %b exp 1", overrun); else n_pass++;
        for (int i = 0; i < 4; i++) do_pop("ovr_drain");
        do_clr();
        n_total++; if (overrun !== 1'b0) $display("FAIL ovr clr got %b exp 0", overrun); else n_pass++;
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        n_total++; if ({rx_valid, frame_err, overrun} !== 3'b000) $display("FAIL glitch state got %b exp 000", {rx_valid, frame_err, overrun}); else n_pass++;
        send_byte(8'h5A);
        n_total++; if (rx_data !== m_head() || rx_count !== 3'd1) $display("FAIL glitch next got %h/%0d exp %h/1", rx_data, rx_count, m_head()); else n_pass++;
        do_pop("glitch");
    endtask

    task automatic test_break();
        send_frame(8'hA5, 1'b0);
        m_fe = 1'b1;
        n_total++; if (frame_err !== m_fe) $display("FAIL break fe got %b exp 1", frame_err); else n_pass++;
        n_total++; if (rx_count !== 3'd0) $display("FAIL break count got %0d exp 0", rx_count); else n_pass++;
        do_clr();
        repeat (480) @(negedge clk);
        n_total++; if (frame_err !== 1'b0) $display("FAIL break refire got %b exp 0", frame_err); else n_pass++;
        rxd = 1'b1;
        repeat (12) @(negedge clk);
        send_byte(8'h3C);
        n_total++; if (rx_count !== 3'd1 || rx_data !== 8'h3C) $display("FAIL break fifo got %0d/%h exp 1/3c", rx_count, rx_data); else n_pass++;
        do_pop("break");
        // clr_err in the same cycle as a framing error: the error must stay set.
        fork
            send_frame(8'h99, 1'b0);
            begin
                repeat (116) @(posedge clk);
                @(negedge clk) clr_err = 1'b1;
                @(negedge clk) clr_err = 1'b0;
            end
        join
        n_total++; if (frame_err !== 1'b1) $display("FAIL set_wins fe got %b exp 1", frame_err); else n_pass++;
        rxd = 1'b1;
        repeat (12) @(negedge clk);
        do_clr();
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        fork
            send_frame(8'hC5, 1'b1);
            begin
                repeat (116) @(posedge clk);
                @(negedge clk);
                n_total++; if (rx_data !== m_head()) $display("FAIL fullpp popped got %h exp %h", rx_data, m_head()); else n_pass++;
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        void'(q.pop_front());
        q.push_back(8'hC5);
        n_total++; if (overrun !== 1'b0) $display("FAIL fullpp overrun got %b exp 0", overrun); else n_pass++;
        n_total++; if (rx_count !== 3'd4) $display("FAIL fullpp count got %0d exp 4", rx_count); else n_pass++;
        for (int i = 0; i < 4; i++) do_pop("fullpp_drain");
    endtask

    task automatic test_reset_mid();
        send_byte(8'h11);
        rxd = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = i[0] ? 1'b1 : 1'b0;
            repeat (12) @(negedge clk);
        end
        resetn = 1'b0;
        #1;
        q.delete();
        m_fe = 1'b0; m_ov = 1'b0;
        n_total++; if ({rx_data, rx_valid, rx_count, frame_err, overrun} !== 13'd0) $display("FAIL reset_mid outputs got %h exp 0", {rx_data, rx_valid, rx_count, frame_err, overrun}); else n_pass++;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        send_byte(8'h81);
        n_total++; if (rx_count !== 3'd1 || rx_data !== 8'h81) $display("FAIL reset_mid next got %0d/%h exp 1/81", rx_count, rx_data); else n_pass++;
        do_pop("reset_mid");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'($urandom));
            n_total++; if (rx_count !== 3'(q.size()) || rx_data !== m_head()) $display("FAIL rand%0d fifo got %0d/%h exp %0d/%h", i, rx_count, rx_data, q.size(), m_head()); else n_pass++;
            n_total++; if (overrun !== m_ov || frame_err !== m_fe) $display("FAIL rand%0d flags got %b%b exp %b%b", i, overrun, frame_err, m_ov, m_fe); else n_pass++;
            repeat ($urandom_range(0, 2)) do_pop("rand_pop");
            if ($urandom_range(0, 3) == 0) do_clr();
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_overrun();
        test_glitch();
        test_break();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
